// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: snoops register-file writes of a riscv-tests program and latches a pass/fail/timeout verdict.
module riscv_test_monitor #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DONE_REG    = 26,
    parameter int PASS_REG    = 27,
    parameter int CASE_REG    = 3,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              rd_we_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              test_done_o,
    output logic              test_pass_o,
    output logic              test_timeout_o,
    output logic [DATA_W-1:0] fail_case_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);
    typedef enum logic [1:0] {RUN, SETTLE, DONE, TIMEOUT} state_t;

    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC);

    state_t            state, state_n;
    logic [DATA_W-1:0] sh_pass, sh_pass_n, sh_case, sh_case_n;
    logic [7:0]        settle, settle_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              live, wr, done_wr, to_hit;

    always_comb begin
        live      = state inside {RUN, SETTLE};
        wr        = live && rd_we_i && rd_addr_i != '0;
        done_wr   = wr && rd_addr_i == ADDR_W'(DONE_REG) && rd_data_i == DATA_W'(1);
        to_hit    = TIMEOUT_CYC != 0 && cnt == TO_LAST;
        sh_pass_n = wr && rd_addr_i == ADDR_W'(PASS_REG) ? rd_data_i : sh_pass;
        sh_case_n = wr && rd_addr_i == ADDR_W'(CASE_REG) ? rd_data_i : sh_case;
        cnt_n     = live && cnt != '1 ? cnt + 1'b1 : cnt;
        settle_n  = state == SETTLE ? settle + 8'd1 : settle;
        // a done write beats a coinciding watchdog expiry
        state_n   = state == RUN    ? (done_wr ? (SETTLE_CYC == 0 ? DONE : SETTLE) : to_hit ? TIMEOUT : RUN) :
                    state == SETTLE ? (settle == SETTLE_LAST ? DONE : SETTLE) : state;
        if (clear_i) begin
            state_n   = RUN;
            sh_pass_n = '0;
            sh_case_n = '0;
            settle_n  = '0;
            cnt_n     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            sh_pass <= '0;
            sh_case <= '0;
            settle  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            sh_pass <= sh_pass_n;
            sh_case <= sh_case_n;
            settle  <= settle_n;
            cnt     <= cnt_n;
        end
    end

    assign test_done_o    = state == DONE || state == TIMEOUT;
    assign test_pass_o    = state == DONE && sh_pass == DATA_W'(1);
    assign test_timeout_o = state == TIMEOUT;
    assign fail_case_o    = test_done_o && !test_pass_o ? sh_case : '0;
    assign cycle_cnt_o    = cnt;
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed and random stimulus against a cycle-count based verdict model.
module tb_riscv_test_monitor;
    localparam int SETTLE = 2;
    localparam int TO     = 64;

    logic        clk = 0, rst_n = 0, clear = 0, we = 0;
    logic [4:0]  addr = 0;
    logic [31:0] data = 0;
    logic        done, pass, tmo;
    logic [31:0] fcase, cnt;

    int n_cmp = 0, n_bad = 0;

    int          m_cnt = 0, m_done = -1;
    bit          m_to = 0;
    logic [31:0] m_pass = 0, m_case = 0;

    riscv_test_monitor #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .rd_we_i(we), .rd_addr_i(addr),
        .rd_data_i(data), .test_done_o(done), .test_pass_o(pass), .test_timeout_o(tmo),
        .fail_case_o(fcase), .cycle_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit verdict();
        return m_done >= 0 && m_cnt >= m_done + (SETTLE == 0 ? 1 : SETTLE + 2);
    endfunction

    function automatic void m_reset();
        m_cnt = 0; m_done = -1; m_to = 0; m_pass = 0; m_case = 0;
    endfunction

    // The verdict lands 1+SETTLE edges after the edge that saw the done write
    function automatic void m_edge(input logic w, input logic [4:0] a, input logic [31:0] d, input logic c);
        if (c) begin m_reset(); return; end
        if (verdict() || m_to) return;
        if (w && a == 27) m_pass = d;
        if (w && a == 3)  m_case = d;
        if (m_done < 0) begin
            if (w && a == 26 && d == 1) m_done = m_cnt;
            else if (m_cnt == TO - 1) m_to = 1;
        end
        m_cnt++;
    endfunction

    task automatic check_all();
        bit v = verdict();
        chk("done", done, v || m_to);
        chk("pass", pass, v && !m_to && m_pass == 1);
        chk("timeout", tmo, m_to);
        chk("fail_case", fcase, (m_to || (v && m_pass != 1)) ? m_case : 0);
        chk("cycle_cnt", cnt, m_cnt);
    endtask

    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d, input logic c);
        we = w; addr = a; data = d; clear = c;
        @(posedge clk);
        m_edge(w, a, d, c);
        #1 check_all();
    endtask

    task automatic idle(); step(0, 0, 0, 0); endtask
    task automatic restart(); step(0, 0, 0, 1); endtask

    task automatic async_reset();
        #2 rst_n = 0;
        #1 m_reset();
        check_all();
        #1 rst_n = 1;
    endtask

    initial begin
        #12 check_all();
        rst_n = 1;
        // pass flow
        step(1, 27, 1, 0);
        while (m_cnt < 49) idle();
        step(1, 26, 1, 0);
        idle(); idle();
        chk("pass_early", done, 0);
        idle();
        chk("pass_done", done, 1);
        chk("pass_flag", pass, 1);
        chk("pass_cnt", cnt, 53);
        repeat (5) idle();
        chk("pass_frozen", cnt, 53);
        // fail flow
        restart();
        step(1, 3, 7, 0); step(1, 27, 0, 0); step(1, 26, 1, 0);
        repeat (3) idle();
        chk("fail_pass", pass, 0);
        chk("fail_case", fcase, 7);
        chk("fail_tmo", tmo, 0);
        // ignored done value, then pass written in the last settle cycle
        restart();
        step(1, 26, 2, 0);
        repeat (3) idle();
        chk("x26_2_done", done, 0);
        step(1, 26, 1, 0); idle(); idle();
        step(1, 27, 1, 0);
        chk("late_pass", pass, 1);
        // x0 write then watchdog
        restart();
        step(1, 0, 1, 0);
        while (m_cnt < TO && !done) idle();
        chk("wd_tmo", tmo, 1);
        chk("wd_done", done, 1);
        chk("wd_cnt", cnt, TO);
        // clear in a verdict state
        restart();
        chk("clr_done", done, 0);
        chk("clr_cnt", cnt, 0);
        idle();
        chk("clr_count", cnt, 1);
        // done/timeout tie
        while (m_cnt < TO - 1) idle();
        step(1, 26, 1, 0);
        chk("tie_tmo", tmo, 0);
        repeat (3) idle();
        chk("tie_done", done, 1);
        chk("tie_final_tmo", tmo, 0);
        // reset mid-settle
        restart();
        step(1, 26, 1, 0); idle();
        async_reset();
        chk("rst_done", done, 0);
        repeat (4) idle();
        chk("rst_no_verdict", done, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            case ($urandom_range(4))
                0: a = 0; 1: a = 3; 2: a = 26; 3: a = 27; default: a = 5'($urandom);
            endcase
            case ($urandom_range(3))
                0: d = 0; 1: d = 1; 2: d = 2; default: d = $urandom;
            endcase
            step(1'($urandom_range(1)), a, d, $urandom_range(39) == 0);
            if ($urandom_range(199) == 0) async_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
